// File: rtl/seq_restoring_divider_if.sv
// rtl/seq_restoring_divider_if.sv - request/result bundle of the sequential divider
//
// Purpose : groups the start/operand request and the ready/busy/done/result
//           response of seq_restoring_divider into one connection.
// Signals : start, dividend, divisor (and is_signed when SIGNED_DIV_EN is
//           defined) travel towards the divider; ready, busy, done, quotient,
//           remainder, div_by_zero come back from it.
// Modports: slave  - the divider side
//           master - the requester (pipeline / testbench) side
// Macro   : SIGNED_DIV_EN adds the is_signed request bit.

interface seq_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             is_signed;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
`ifdef SIGNED_DIV_EN
        input  is_signed,
`endif
        output ready,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );

    modport master (
        output start,
        output dividend,
        output divisor,
`ifdef SIGNED_DIV_EN
        output is_signed,
`endif
        input  ready,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle restoring shift-and-subtract divider
//
// Purpose : computes quotient and remainder one quotient bit per clock for the
//           execute stage; the pipeline stalls on busy and takes results on done.
// Ports   : clk  - clock, all state updates on the rising edge
//           rst  - synchronous active-high reset
//           bus  - seq_restoring_divider_if.slave (start/dividend/divisor in,
//                  ready/busy/done/quotient/remainder/div_by_zero out)
// Timing  : start accepted at edge 0 -> done high after edge WIDTH+1
//           (divide-by-zero: after edge 1). Results publish when DONE is left,
//           together with the one-cycle done pulse, and hold until the next
//           result or reset.
// Macro   : SIGNED_DIV_EN adds is_signed: magnitudes are divided and a FIX
//           cycle applies the signs afterwards (latency WIDTH+2).

module seq_restoring_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_restoring_divider_if.slave bus
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] r_q,         r_d;          // partial remainder
    logic [WIDTH-1:0] q_q,         q_d;          // shifting dividend / quotient
    logic [WIDTH-1:0] d_q,         d_d;          // latched divisor
    logic [WIDTH-1:0] dvd_q,       dvd_d;        // raw dividend for divide-by-zero
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             dbz_pend_q,  dbz_pend_d;   // current op is a divide-by-zero
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic             done_q,      done_d;
`ifdef SIGNED_DIV_EN
    logic             sgn_q,       sgn_d;        // op needs the FIX cycle
    logic             neg_quo_q,   neg_quo_d;
    logic             neg_rem_q,   neg_rem_d;
`endif

    logic             ready;
    logic             busy;
    logic             accept;

    // One restoring step. The shifted remainder keeps the bit pushed out of R
    // so divisors above 2^(WIDTH-1) still divide correctly; one more bit on top
    // carries the borrow of the trial subtract.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    assign r_shift = {r_q, q_q[WIDTH-1]};
    assign trial   = {1'b0, r_shift} - {2'b00, d_q};
    assign borrow  = trial[WIDTH+1];

`ifdef SIGNED_DIV_EN
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        dvd_d       = dvd_q;
        cnt_d       = cnt_q;
        dbz_pend_d  = dbz_pend_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
`ifdef SIGNED_DIV_EN
        sgn_d       = sgn_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        ready       = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                ready  = 1'b1;
                accept = bus.start;
                if (bus.start) begin
                    dbz_d = 1'b0;
                end
            end
            RUN: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (!borrow) begin
                    r_d = WIDTH'(trial);
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == LAST_CNT) begin
`ifdef SIGNED_DIV_EN
                    state_d = sgn_q ? FIX : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                busy    = 1'b1;
                q_d     = negate_if(q_q, neg_quo_q);
                r_d     = negate_if(r_q, neg_rem_q);
                state_d = DONE;
            end
`endif
            DONE: begin
                // Publishing reads the current operation's registers, so a
                // back-to-back accept below may reload them on the same edge.
                ready       = 1'b1;
                done_d      = 1'b1;
                quotient_d  = dbz_pend_q ? {WIDTH{1'b1}} : q_q;
                remainder_d = dbz_pend_q ? dvd_q : r_q;
                dbz_d       = dbz_pend_q;
                state_d     = IDLE;
                accept      = bus.start;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            dvd_d = bus.dividend;
            if (bus.divisor == '0) begin
                dbz_pend_d = 1'b1;
                state_d    = DONE;
            end else begin
                dbz_pend_d = 1'b0;
                r_d        = '0;
                cnt_d      = '0;
                state_d    = RUN;
`ifdef SIGNED_DIV_EN
                sgn_d     = bus.is_signed;
                neg_quo_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                neg_rem_d = bus.is_signed & bus.dividend[WIDTH-1];
                q_d       = bus.is_signed ? magnitude(bus.dividend) : bus.dividend;
                d_d       = bus.is_signed ? magnitude(bus.divisor)  : bus.divisor;
`else
                q_d       = bus.dividend;
                d_d       = bus.divisor;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            dvd_q       <= '0;
            cnt_q       <= '0;
            dbz_pend_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
`ifdef SIGNED_DIV_EN
            sgn_q       <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            dvd_q       <= dvd_d;
            cnt_q       <= cnt_d;
            dbz_pend_q  <= dbz_pend_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
`ifdef SIGNED_DIV_EN
            sgn_q       <= sgn_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.ready       = ready;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - randomized self-checking bench for seq_restoring_divider

module tb_seq_restoring_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    seq_restoring_divider_if #(.WIDTH(W)) dif ();

    seq_restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic from the behavioural rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat, output int bsy);
        if (b == 0) begin
            q = '1; r = a; z = 1'b1; lat = 1; bsy = 0;
        end else if (s) begin
            z = 1'b0; lat = W + 2; bsy = W + 1;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000; r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = W + 1; bsy = W;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int k = 0;
        @(negedge clk);
        while (!dif.ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!dif.ready) check_eq("ready_wait", 64'(dif.ready), 64'd1);
        dif.dividend = a;
        dif.divisor  = b;
`ifdef SIGNED_DIV_EN
        dif.is_signed = s;
`else
        if (s) $display("note: signed request ignored in unsigned build");
`endif
        dif.start = 1'b1;
        @(posedge clk);
        #1;
        dif.start    = 1'b0;
        dif.dividend = $urandom;  // latched operands must not care
        dif.divisor  = $urandom;
    endtask

    // Returns at the negedge where done is seen; cyc counts edges after edge 0.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0; bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dif.done) break;
            if (dif.busy) bcnt++;
            @(posedge clk);
            cyc++;
        end
        if (!dif.done) check_eq("done_timeout", 64'(dif.done), 64'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
        logic [W-1:0] eq, er;
        logic ez;
        int elat, ebsy, cyc, bcnt;
        model(a, b, s, eq, er, ez, elat, ebsy);
        start_op(a, b, s);
        wait_done(cyc, bcnt);
        check_eq({tag, ".quotient"}, 64'(dif.quotient), 64'(eq));
        check_eq({tag, ".remainder"}, 64'(dif.remainder), 64'(er));
        check_eq({tag, ".dbz"}, 64'(dif.div_by_zero), 64'(ez));
        check_eq({tag, ".latency"}, 64'(cyc), 64'(elat));
        check_eq({tag, ".busy_cycles"}, 64'(bcnt), 64'(ebsy));
        @(negedge clk);
        check_eq({tag, ".done_one_cycle"}, 64'(dif.done), 64'd0);
    endtask

    initial begin
        logic [W-1:0] a, b, eq, er;
        logic ez, s;
        int elat, ebsy, cyc, bcnt, seen;

        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
`ifdef SIGNED_DIV_EN
        dif.is_signed = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst.ready", 64'(dif.ready), 64'd1);
        check_eq("rst.busy", 64'(dif.busy), 64'd0);
        check_eq("rst.done", 64'(dif.done), 64'd0);
        check_eq("rst.quotient", 64'(dif.quotient), 64'd0);
        check_eq("rst.remainder", 64'(dif.remainder), 64'd0);
        check_eq("rst.dbz", 64'(dif.div_by_zero), 64'd0);

        run_and_check("basic", 32'd100, 32'd7, 1'b0);
        run_and_check("dbz", 32'h1234, 32'd0, 1'b0);
        run_and_check("big_divisor", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_and_check("equal", 32'h8000_0001, 32'h8000_0001, 1'b0);
        run_and_check("small_by_big", 32'd5, 32'hF000_0000, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a = (($urandom & 1) != 0) ? $urandom : $urandom_range(0, 1000);
            case ($urandom_range(0, 7))
                0:       b = 0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
`ifdef SIGNED_DIV_EN
            s = 1'($urandom & 1);
`else
            s = 1'b0;
`endif
            run_and_check($sformatf("rand%0d", i), a, b, s);
        end

        // Back-to-back with a start during RUN that must be ignored.
        start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (5) @(negedge clk);
        check_eq("b2b.ready_in_run", 64'(dif.ready), 64'd0);
        dif.dividend = 32'd5;
        dif.divisor  = 32'd5;
        dif.start    = 1'b1;
        @(posedge clk);
        #1 dif.start = 1'b0;
        wait_done(cyc, bcnt);
        check_eq("b2b.q1", 64'(dif.quotient), 64'hFFFF_FFFF);
        check_eq("b2b.r1", 64'(dif.remainder), 64'd0);
        check_eq("b2b.ready_at_done", 64'(dif.ready), 64'd1);
        dif.dividend = 32'd9;
        dif.divisor  = 32'd4;
        dif.start    = 1'b1;
        @(posedge clk);
        #1 dif.start = 1'b0;
        dif.dividend = $urandom;
        wait_done(cyc, bcnt);
        check_eq("b2b.q2", 64'(dif.quotient), 64'd2);
        check_eq("b2b.r2", 64'(dif.remainder), 64'd1);
        check_eq("b2b.latency2", 64'(cyc), 64'(W + 1));

        // Reset in the middle of a division.
        start_op(32'd1000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("midrst.ready", 64'(dif.ready), 64'd1);
        check_eq("midrst.busy", 64'(dif.busy), 64'd0);
        check_eq("midrst.quotient", 64'(dif.quotient), 64'd0);
        check_eq("midrst.remainder", 64'(dif.remainder), 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.done) seen++;
        end
        check_eq("midrst.no_done", 64'(seen), 64'd0);
        run_and_check("after_rst", 32'd1000, 32'd3, 1'b0);

`ifdef SIGNED_DIV_EN
        run_and_check("s_neg7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_and_check("s_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_and_check("s_dbz", 32'hFFFF_FF00, 32'd0, 1'b1);
        run_and_check("s_off", 32'hFFFF_FFF9, 32'd2, 1'b0);
`endif

        model(32'd0, 32'd1, 1'b0, eq, er, ez, elat, ebsy);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
